// File: rtl/sprite_collision_unit.sv
// Pixel compositor for two tank sprites over a playfield, with per-frame
// collision accumulation published on each vsync rising edge.
module sprite_collision_unit #(
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       hpos,
  input  logic [8:0]       vpos,
  input  logic             display_on,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             sprite0_gfx,
  input  logic             sprite1_gfx,
  input  logic             playfield_gfx,
  output logic [2:0]       rgb,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             coll_s0_pf,
  output logic             coll_s1_pf,
  output logic             coll_s0_s1,
  output logic [8:0]       hit_x,
  output logic [8:0]       hit_y,
  output logic [HIT_W-1:0] hit_count,
  output logic             frame_done
);

  localparam logic [HIT_W-1:0] ONE = {{(HIT_W-1){1'b0}}, 1'b1};

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != {HIT_W{1'b1}}))
      return cnt + ONE;
    return cnt;
  endfunction

  // Fixed priority: sprite overlap, sprite0, sprite1, playfield, background.
  function automatic logic [2:0] compose(input logic on, input logic s0,
                                         input logic s1, input logic pf);
    if (!on)          return 3'b000;
    if (s0 && s1)     return 3'b111;
    if (s0)           return 3'b011;
    if (s1)           return 3'b110;
    if (pf)           return 3'b100;
    return 3'b000;
  endfunction

  logic             vsync_q;
  logic             acc_s0_pf, acc_s1_pf, acc_s0_s1;
  logic [HIT_W-1:0] acc_count;
  logic [8:0]       acc_x, acc_y;
  logic             first_seen;

  logic rise, hit_s0_pf, hit_s1_pf, hit_s0_s1;

  assign rise      = vsync && !vsync_q;
  assign hit_s0_pf = display_on && sprite0_gfx && playfield_gfx;
  assign hit_s1_pf = display_on && sprite1_gfx && playfield_gfx;
  assign hit_s0_s1 = display_on && sprite0_gfx && sprite1_gfx;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb        <= 3'b000;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vsync_q    <= 1'b0;
      frame_done <= 1'b0;
      coll_s0_pf <= 1'b0;
      coll_s1_pf <= 1'b0;
      coll_s0_s1 <= 1'b0;
      hit_x      <= 9'd0;
      hit_y      <= 9'd0;
      hit_count  <= '0;
      acc_s0_pf  <= 1'b0;
      acc_s1_pf  <= 1'b0;
      acc_s0_s1  <= 1'b0;
      acc_count  <= '0;
      acc_x      <= 9'd0;
      acc_y      <= 9'd0;
      first_seen <= 1'b0;
    end else begin
      rgb        <= compose(display_on, sprite0_gfx, sprite1_gfx, playfield_gfx);
      hsync_out  <= hsync;
      vsync_out  <= vsync;
      vsync_q    <= vsync;
      frame_done <= rise;
      if (rise) begin
        // Publish including any hit on the edge cycle itself, then start fresh.
        coll_s0_pf <= acc_s0_pf | hit_s0_pf;
        coll_s1_pf <= acc_s1_pf | hit_s1_pf;
        coll_s0_s1 <= acc_s0_s1 | hit_s0_s1;
        hit_count  <= sat_inc(acc_count, hit_s0_pf);
        hit_x      <= first_seen ? acc_x : (hit_s0_pf ? hpos : 9'd0);
        hit_y      <= first_seen ? acc_y : (hit_s0_pf ? vpos : 9'd0);
        acc_s0_pf  <= 1'b0;
        acc_s1_pf  <= 1'b0;
        acc_s0_s1  <= 1'b0;
        acc_count  <= '0;
        acc_x      <= 9'd0;
        acc_y      <= 9'd0;
        first_seen <= 1'b0;
      end else begin
        acc_s0_pf <= acc_s0_pf | hit_s0_pf;
        acc_s1_pf <= acc_s1_pf | hit_s1_pf;
        acc_s0_s1 <= acc_s0_s1 | hit_s0_s1;
        acc_count <= sat_inc(acc_count, hit_s0_pf);
        if (hit_s0_pf && !first_seen) begin
          acc_x      <= hpos;
          acc_y      <= vpos;
          first_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_collision_unit.sv
// Directed bench for sprite_collision_unit: a frame-level model checked every
// cycle, plus literal expectations for each scenario.
module tb_sprite_collision_unit;

  localparam int HIT_W = 8;

  logic clk = 1'b0;
  logic reset, display_on, hsync, vsync, s0, s1, pf;
  logic [8:0] hpos, vpos;
  logic [2:0] rgb;
  logic hsync_out, vsync_out, coll_s0_pf, coll_s1_pf, coll_s0_s1, frame_done;
  logic [8:0] hit_x, hit_y;
  logic [HIT_W-1:0] hit_count;

  sprite_collision_unit #(.HIT_W(HIT_W)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync(hsync), .vsync(vsync),
    .sprite0_gfx(s0), .sprite1_gfx(s1), .playfield_gfx(pf),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .coll_s0_pf(coll_s0_pf), .coll_s1_pf(coll_s1_pf), .coll_s0_s1(coll_s0_s1),
    .hit_x(hit_x), .hit_y(hit_y), .hit_count(hit_count),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int fd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a list of sprite0/playfield hit positions per frame.
  logic [17:0] hits[$];
  bit m_s1pf, m_s0s1, m_prev_vs;
  logic [2:0] e_rgb;
  bit e_hs, e_vs, e_fd, e_c0, e_c1, e_c01;
  int e_x, e_y, e_cnt;

  always @(posedge clk) begin
    if (reset) begin
      hits.delete();
      {m_s1pf, m_s0s1, m_prev_vs} = '0;
      e_rgb = 3'b000;
      {e_hs, e_vs, e_fd, e_c0, e_c1, e_c01} = '0;
      e_x = 0; e_y = 0; e_cnt = 0;
    end else begin
      if (!display_on)    e_rgb = 3'b000;
      else if (s0 && s1)  e_rgb = 3'b111;
      else if (s0)        e_rgb = 3'b011;
      else if (s1)        e_rgb = 3'b110;
      else if (pf)        e_rgb = 3'b100;
      else                e_rgb = 3'b000;
      e_hs = hsync;
      e_vs = vsync;
      if (display_on) begin
        if (s0 && pf) hits.push_back({hpos, vpos});
        if (s1 && pf) m_s1pf = 1'b1;
        if (s0 && s1) m_s0s1 = 1'b1;
      end
      e_fd = vsync && !m_prev_vs;
      if (e_fd) begin
        e_c0  = hits.size() > 0;
        e_c1  = m_s1pf;
        e_c01 = m_s0s1;
        e_cnt = (hits.size() > 255) ? 255 : hits.size();
        e_x   = (hits.size() > 0) ? int'(hits[0][17:9]) : 0;
        e_y   = (hits.size() > 0) ? int'(hits[0][8:0]) : 0;
        hits.delete();
        m_s1pf = 1'b0;
        m_s0s1 = 1'b0;
      end
      m_prev_vs = vsync;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rgb", rgb, e_rgb);
      chk("hsync_out", hsync_out, e_hs);
      chk("vsync_out", vsync_out, e_vs);
      chk("frame_done", frame_done, e_fd);
      chk("coll_s0_pf", coll_s0_pf, e_c0);
      chk("coll_s1_pf", coll_s1_pf, e_c1);
      chk("coll_s0_s1", coll_s0_s1, e_c01);
      chk("hit_x", hit_x, e_x);
      chk("hit_y", hit_y, e_y);
      chk("hit_count", hit_count, e_cnt);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input bit on, input bit a, input bit b, input bit p,
                     input int x, input int y);
    display_on = on; s0 = a; s1 = b; pf = p;
    hpos = 9'(x); vpos = 9'(y);
    hsync = (x % 7) == 3;
    step();
  endtask

  // Raise vsync in blanking; returns one clk after the sampling edge.
  task automatic frame_rise();
    display_on = 0; s0 = 0; s1 = 0; pf = 0; vsync = 1;
    step();
  endtask

  task automatic frame_fall(input int hold);
    for (int i = 1; i < hold; i++) step();
    vsync = 0;
    step();
  endtask

  task automatic frame();
    frame_rise();
    frame_fall(3);
  endtask

  initial begin
    int fd0;
    reset = 1; display_on = 0; hsync = 0; vsync = 0;
    s0 = 0; s1 = 0; pf = 0; hpos = 0; vpos = 0;
    step();
    chk_en = 1'b1;
    step();
    chk("reset rgb", rgb, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset hit_count", hit_count, 0);
    reset = 0;
    step();

    // Priority
    pix(1, 1, 1, 1, 10, 5); chk("prio white", rgb, 3'b111);
    pix(1, 1, 0, 1, 11, 5); chk("prio yellow", rgb, 3'b011);
    pix(1, 0, 1, 1, 12, 5); chk("prio cyan", rgb, 3'b110);
    pix(1, 0, 0, 1, 13, 5); chk("prio blue", rgb, 3'b100);
    pix(0, 1, 1, 1, 14, 5); chk("prio blank", rgb, 3'b000);
    frame();

    // First-hit capture, including a hit on the first visible column/row
    pix(1, 0, 0, 0, 0, 0);
    pix(1, 1, 0, 1, 40, 30);
    pix(1, 1, 0, 1, 41, 30);
    pix(1, 0, 0, 0, 42, 30);
    fd0 = fd_cnt;
    frame_rise();
    chk("first frame_done", frame_done, 1);
    chk("first coll_s0_pf", coll_s0_pf, 1);
    chk("first hit_x", hit_x, 40);
    chk("first hit_y", hit_y, 30);
    chk("first hit_count", hit_count, 2);
    chk("first coll_s1_pf", coll_s1_pf, 0);
    chk("first coll_s0_s1", coll_s0_s1, 0);
    frame_fall(3);
    chk("first single pulse", fd_cnt - fd0, 1);
    pix(1, 1, 0, 1, 0, 0);
    frame();
    chk("origin hit_x", hit_x, 0);
    chk("origin hit_count", hit_count, 1);

    // Blanking ignored
    for (int i = 0; i < 20; i++) pix(0, 1, 1, 1, 50 + i, 60);
    frame();
    chk("blank coll_s0_pf", coll_s0_pf, 0);
    chk("blank coll_s0_s1", coll_s0_s1, 0);
    chk("blank hit_count", hit_count, 0);
    chk("blank hit_x", hit_x, 0);

    // Saturation
    for (int i = 0; i < 300; i++) pix(1, 1, 0, 1, 100 + (i % 150), 50 + i / 150);
    frame();
    chk("sat hit_count", hit_count, 255);
    chk("sat hit_x", hit_x, 100);
    chk("sat hit_y", hit_y, 50);
    for (int i = 0; i < 10; i++) pix(1, 0, 0, 1, i, 1);
    chk("sat hold", hit_count, 255);
    frame();
    chk("empty hit_count", hit_count, 0);
    chk("empty coll_s0_pf", coll_s0_pf, 0);

    // Sprite-sprite and long vsync
    pix(1, 1, 1, 0, 80, 90);
    pix(1, 1, 1, 0, 81, 90);
    fd0 = fd_cnt;
    frame_rise();
    frame_fall(100);
    chk("long vsync pulses", fd_cnt - fd0, 1);
    chk("ss coll_s0_s1", coll_s0_s1, 1);
    chk("ss coll_s0_pf", coll_s0_pf, 0);
    chk("ss coll_s1_pf", coll_s1_pf, 0);
    pix(1, 0, 1, 1, 5, 5);
    frame();
    chk("s1pf coll_s1_pf", coll_s1_pf, 1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) pix(1, 1, 0, 1, 20 + i, 20);
    reset = 1;
    pix(1, 1, 1, 1, 30, 20);
    chk("rst rgb", rgb, 0);
    chk("rst coll_s1_pf", coll_s1_pf, 0);
    chk("rst hit_count", hit_count, 0);
    reset = 0;
    pix(0, 0, 0, 0, 0, 0);
    chk("post rst coll_s1_pf", coll_s1_pf, 0);
    chk("post rst frame_done", frame_done, 0);
    frame();
    chk("rst frame hit_count", hit_count, 0);
    chk("rst frame coll_s0_pf", coll_s0_pf, 0);

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_collision_unit.md
# sprite_collision_unit

Per-pixel compositor and collision detector sitting directly downstream of the tank sprite renderers and the playfield generator. Takes the 1-bit pixel streams from two sprites and the playfield, produces the registered RGB output with fixed priority, and accumulates per-frame collision flags, a first-hit position and a hit count. Results are published once per frame on the vsync rising edge, so game logic in the vsync domain reads stable values.

## Interface
- HIT_W, default 8: width of the per-frame sprite0/playfield hit counter; the counter saturates.
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hpos  in  9  current horizontal position from hvsync_generator
- vpos  in  9  current vertical position from hvsync_generator
- display_on  in  1  visible-area flag
- hsync  in  1  raw hsync
- vsync  in  1  raw vsync
- sprite0_gfx  in  1  pixel from tank 0 renderer
- sprite1_gfx  in  1  pixel from tank 1 renderer
- playfield_gfx  in  1  pixel from playfield generator
- rgb  out  3  {b,g,r}, registered
- hsync_out  out  1  hsync delayed 1 clk, aligned with rgb
- vsync_out  out  1  vsync delayed 1 clk, aligned with rgb
- coll_s0_pf  out  1  sprite0 overlapped playfield last frame
- coll_s1_pf  out  1  sprite1 overlapped playfield last frame
- coll_s0_s1  out  1  sprites overlapped each other last frame
- hit_x  out  9  hpos of first sprite0/playfield overlap last frame
- hit_y  out  9  vpos of the same pixel
- hit_count  out  HIT_W  count of sprite0/playfield overlap pixels last frame, saturating
- frame_done  out  1  one-clk pulse when the results above update

## Operation
- Sampling: a pixel counts only when display_on=1. Inputs outside the visible area never affect rgb, accumulators, or hit position.
- Compositor, registered, priority high to low:
  - s0&s1: 3'b111 (white)
  - s0 only: 3'b011 (yellow)
  - s1 only: 3'b110 (cyan)
  - playfield only: 3'b100 (blue)
  - none, or display_on=0: 3'b000
- Accumulators, internal: acc_s0_pf, acc_s1_pf, acc_s0_s1 (sticky OR), acc_count (saturating at 2^HIT_W-1), acc_x/acc_y, and a first_seen flag.
  - On the first s0&pf pixel of a frame (first_seen=0), capture hpos/vpos and set first_seen.
  - Later s0&pf pixels do not overwrite the captured position.
- Frame boundary: vsync_q holds the previous vsync. A rising edge is vsync=1 && vsync_q=0. On that cycle:
  - All outputs coll_*, hit_x, hit_y and hit_count take the accumulator values, including any hit in that same cycle. In practice display_on=0 during vsync, so there is none.
  - All accumulators and first_seen clear.
  - frame_done pulses high for exactly that one cycle.
- When no s0&pf hit occurred in a frame, hit_x=0 and hit_y=0 are published.
- Published outputs hold between frame edges, regardless of input activity.

## Timing
- rgb, hsync_out and vsync_out each have exactly 1 clk latency from the inputs.
- frame_done is registered and asserts in the clk after the sampled rising edge, together with the updated result outputs.
- Reset: all outputs are 0, including rgb, hsync_out, vsync_out and frame_done. All accumulators are 0, first_seen=0, vsync_q=0.
- Reset mid-frame discards partial accumulation. vsync_q=0 after reset, so if vsync is already high when reset releases, it is treated as a rising edge on the next clk. This is acceptable: it publishes zeros.
- vsync held high for many clks: only one frame_done is produced.
- Counter saturation: acc_count stays at max and never wraps.
- A sprite pixel exactly at the first visible column/row counts normally. There is no edge masking.

## Test plan
- Priority: with display_on=1, drive s0=1,s1=1,pf=1 -> rgb=3'b111 one clk later. Then s1=0 -> 3'b011. Then s0=0,s1=1 -> 3'b110. Then pf only -> 3'b100. Then display_on=0 -> 3'b000.
- First hit capture: overlap s0&pf at (hpos,vpos)=(40,30) and again at (41,30), then a vsync rising edge -> frame_done pulse once, coll_s0_pf=1, hit_x=40, hit_y=30, hit_count=2, other flags 0.
- Blanking ignored: s0&pf=1 only while display_on=0 across a whole frame -> after vsync edge all flags 0, hit_count=0, hit_x=hit_y=0.
- Saturation: 300 overlap pixels with HIT_W=8 -> hit_count=255. The next frame with zero hits publishes hit_count=0 and coll_s0_pf=0.
- Sprite-sprite: s0&s1 overlap with pf=0 -> coll_s0_s1=1, coll_s0_pf=0, coll_s1_pf=0. vsync held high 100 clks -> exactly one frame_done.
- Reset mid-frame: accumulate 5 hits, assert reset 1 clk, then run to a vsync edge with no hits -> hit_count=0, all outputs 0 during and immediately after reset.
